// File: rtl/vect_pkg.sv
// vect_pkg: vector opcode constants {op[3:0], type[2:0]} and logic sequencer state type
package vect_pkg;
   localparam logic [2:0] INT  = 3'd0;
   localparam logic [2:0] MULT = 3'd1;
   localparam logic [3:0] VAND            = 4'd1;
   localparam logic [3:0] VOR             = 4'd2;
   localparam logic [3:0] VXOR            = 4'd3;
   localparam logic [3:0] VMSEQ_VMANDNOT  = 4'd4;
   localparam logic [3:0] VMSNE_VMAND     = 4'd5;
   localparam logic [3:0] VMSLTU_VMOR     = 4'd6;
   localparam logic [3:0] VMSLT_VMXOR     = 4'd7;
   localparam logic [3:0] VMSLEU_VMORNOT  = 4'd8;
   localparam logic [3:0] VMSLE_VMNAND    = 4'd9;
   localparam logic [3:0] VMSGTU_VMNOR    = 4'd10;
   localparam logic [3:0] VMSGT_VMXNOR    = 4'd11;
   typedef enum logic [2:0] {IDLE, FETCH, EXEC, WB, FIN} logic_seq_state_t;
   // mask-logical ops occupy the contiguous MULT range VMSEQ_VMANDNOT..VMSGT_VMXNOR
   function automatic logic is_logic_op(input logic [6:0] oc);
      return (oc[2:0] == INT && oc[6:3] inside {VAND, VOR, VXOR}) ||
             (oc[2:0] == MULT && oc[6:3] >= VMSEQ_VMANDNOT && oc[6:3] <= VMSGT_VMXNOR);
   endfunction
endpackage

// File: rtl/logic_seq.sv
// logic_seq: per-element sequencer feeding an external logic unit (fetch, exec, write-back)
module logic_seq
   import vect_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int MAX_VL     = 32,
   parameter int IDX_W      = $clog2(MAX_VL),
   parameter int VL_W       = $clog2(MAX_VL+1)
) (
   input  logic                  module_clk_i,
   input  logic                  rst_ni,
   input  logic                  req_valid_i,
   output logic                  req_ready_o,
   input  logic [6:0]            req_ocode_i,
   input  logic [VL_W-1:0]       req_vl_i,
   input  logic                  req_scalar_i,
   input  logic [DATA_WIDTH-1:0] req_rs1_i,
   output logic                  rd_en_o,
   output logic [IDX_W-1:0]      rd_idx_o,
   input  logic [DATA_WIDTH-1:0] rd_a_i,
   input  logic [DATA_WIDTH-1:0] rd_b_i,
   output logic                  logic_e_o,
   output logic [DATA_WIDTH-1:0] logic_a_o,
   output logic [DATA_WIDTH-1:0] logic_b_o,
   output logic [6:0]            logic_ocode_o,
   input  logic [DATA_WIDTH-1:0] logic_result_i,
   output logic                  wb_valid_o,
   input  logic                  wb_ready_i,
   output logic [IDX_W-1:0]      wb_idx_o,
   output logic [DATA_WIDTH-1:0] wb_data_o,
   output logic                  busy_o,
   output logic                  done_o,
   output logic                  err_o
);
   logic_seq_state_t      state_q, state_d;
   logic [IDX_W-1:0]      idx_q, idx_d, wb_idx_q, wb_idx_d;
   logic [VL_W-1:0]       vl_q, vl_d;
   logic [6:0]            ocode_q, ocode_d;
   logic                  scalar_q, scalar_d, last;
   logic [DATA_WIDTH-1:0] rs1_q, rs1_d, wb_data_q, wb_data_d;

   always_ff @(posedge module_clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= IDLE;
         idx_q     <= '0;
         vl_q      <= '0;
         ocode_q   <= '0;
         scalar_q  <= 1'b0;
         rs1_q     <= '0;
         wb_idx_q  <= '0;
         wb_data_q <= '0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         vl_q      <= vl_d;
         ocode_q   <= ocode_d;
         scalar_q  <= scalar_d;
         rs1_q     <= rs1_d;
         wb_idx_q  <= wb_idx_d;
         wb_data_q <= wb_data_d;
      end
   end

   assign last = VL_W'(idx_q) == vl_q - VL_W'(1);

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      vl_d      = vl_q;
      ocode_d   = ocode_q;
      scalar_d  = scalar_q;
      rs1_d     = rs1_q;
      wb_idx_d  = wb_idx_q;
      wb_data_d = wb_data_q;
      case (state_q)
         IDLE: if (req_valid_i) begin
            ocode_d  = req_ocode_i;
            vl_d     = req_vl_i > VL_W'(MAX_VL) ? VL_W'(MAX_VL) : req_vl_i;
            scalar_d = req_scalar_i;
            rs1_d    = req_rs1_i;
            idx_d    = '0;
            state_d  = (!is_logic_op(req_ocode_i) || req_vl_i == '0) ? FIN : FETCH;
         end
         FETCH: state_d = EXEC;
         EXEC: begin
            wb_data_d = logic_result_i;
            wb_idx_d  = idx_q;
            state_d   = WB;
         end
         WB: if (wb_ready_i) begin
            idx_d   = last ? idx_q : idx_q + IDX_W'(1);
            state_d = last ? FIN : FETCH;
         end
         default: state_d = IDLE;
      endcase
   end

   // operands are forced to zero outside EXEC so the downstream unit sees no toggling
   assign req_ready_o   = state_q == IDLE;
   assign busy_o        = state_q != IDLE;
   assign rd_en_o       = state_q == FETCH;
   assign rd_idx_o      = idx_q;
   assign logic_e_o     = state_q == EXEC;
   assign logic_a_o     = logic_e_o ? (scalar_q ? rs1_q : rd_a_i) : '0;
   assign logic_b_o     = logic_e_o ? rd_b_i : '0;
   assign logic_ocode_o = ocode_q;
   assign wb_valid_o    = state_q == WB;
   assign wb_idx_o      = wb_idx_q;
   assign wb_data_o     = wb_data_q;
   assign done_o        = state_q == FIN;
   assign err_o         = done_o && !is_logic_op(ocode_q);
endmodule

// File: tb/tb_logic_seq.sv
// tb_logic_seq: directed vectors against logic_seq with a behavioural register file and logic unit
module tb_logic_seq;
   import vect_pkg::*;
   localparam int DW = 32, IW = 5, VW = 6;
   localparam logic [6:0] OC_AND  = {VAND, INT};
   localparam logic [6:0] OC_OR   = {VOR, INT};
   localparam logic [6:0] OC_XOR  = {VXOR, INT};
   localparam logic [6:0] OC_XNOR = {VMSGT_VMXNOR, MULT};

   logic clk = 1'b0, rst_ni;
   logic req_valid_i, req_ready_o, req_scalar_i;
   logic [6:0] req_ocode_i, logic_ocode_o;
   logic [VW-1:0] req_vl_i;
   logic [DW-1:0] req_rs1_i, rd_a_i, rd_b_i, logic_a_o, logic_b_o, logic_result_i, wb_data_o;
   logic rd_en_o, logic_e_o, wb_valid_o, wb_ready_i, busy_o, done_o, err_o;
   logic [IW-1:0] rd_idx_o, wb_idx_o;

   logic_seq dut (
      .module_clk_i(clk), .rst_ni(rst_ni),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_ocode_i(req_ocode_i),
      .req_vl_i(req_vl_i), .req_scalar_i(req_scalar_i), .req_rs1_i(req_rs1_i),
      .rd_en_o(rd_en_o), .rd_idx_o(rd_idx_o), .rd_a_i(rd_a_i), .rd_b_i(rd_b_i),
      .logic_e_o(logic_e_o), .logic_a_o(logic_a_o), .logic_b_o(logic_b_o),
      .logic_ocode_o(logic_ocode_o), .logic_result_i(logic_result_i),
      .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i), .wb_idx_o(wb_idx_o),
      .wb_data_o(wb_data_o), .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
   );

   always #5 clk = ~clk;

   logic [DW-1:0] ma [32], mb [32];
   always @(posedge clk) if (rd_en_o) begin
      rd_a_i <= ma[rd_idx_o];
      rd_b_i <= mb[rd_idx_o];
   end

   always_comb begin
      logic_result_i = logic_a_o ^ logic_b_o;
      if (logic_ocode_o == OC_AND) logic_result_i = logic_a_o & logic_b_o;
      if (logic_ocode_o == OC_OR) logic_result_i = logic_a_o | logic_b_o;
      if (logic_ocode_o == OC_XNOR) logic_result_i = ~(logic_a_o ^ logic_b_o);
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int rd_cnt = 0, wb_cnt = 0, vld_cnt = 0, err_cnt = 0, unstable = 0, acc_cyc = 0, err_cyc = 0;
   logic [DW-1:0] wb_dat [256], exec_a;
   logic [IW-1:0] wb_ix [256];
   logic prev_v = 1'b0;
   logic [DW-1:0] prev_d;
   logic [IW-1:0] prev_i;
   always @(negedge clk) begin
      if (rd_en_o) rd_cnt++;
      if (logic_e_o) exec_a = logic_a_o;
      if (wb_valid_o) vld_cnt++;
      if (wb_valid_o && prev_v && (wb_data_o != prev_d || wb_idx_o != prev_i)) unstable++;
      if (wb_valid_o && wb_ready_i) begin
         wb_dat[wb_cnt] = wb_data_o;
         wb_ix[wb_cnt]  = wb_idx_o;
         wb_cnt++;
         acc_cyc = cyc;
      end
      if (err_o) begin err_cnt++; err_cyc = cyc; end
      prev_v = wb_valid_o;
      prev_d = wb_data_o;
      prev_i = wb_idx_o;
   end

   int n_vec = 0, n_err = 0, hs_cyc = 0, done_at = 0;
   int rd0, wb0, vl0, er0;

   task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic snap();
      rd0 = rd_cnt; wb0 = wb_cnt; vl0 = vld_cnt; er0 = err_cnt;
   endtask

   task automatic start(input logic [6:0] oc, input int vl, input logic sc, input logic [DW-1:0] r);
      snap();
      req_ocode_i = oc; req_vl_i = VW'(vl); req_scalar_i = sc; req_rs1_i = r; req_valid_i = 1'b1;
      @(negedge clk);
      hs_cyc = cyc;
      chk("req_ready", DW'(req_ready_o), 1);
      @(posedge clk); #1 req_valid_i = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      int i = 0;
      @(negedge clk);
      while (!done_o && i < budget) begin @(negedge clk); i++; end
      chk("done_seen", DW'(done_o), 1);
      done_at = cyc;
      @(posedge clk); #1;
   endtask

   task automatic chk_idle_outputs(input string tag);
      chk({tag, "_busy"}, DW'(busy_o), 0);
      chk({tag, "_ready"}, DW'(req_ready_o), 1);
      chk({tag, "_strobes"}, DW'({wb_valid_o, done_o, err_o, rd_en_o, logic_e_o}), 0);
      chk({tag, "_wb_data"}, wb_data_o, 0);
      chk({tag, "_wb_idx"}, DW'(wb_idx_o), 0);
      chk({tag, "_ops"}, logic_a_o | logic_b_o, 0);
   endtask

   initial begin
      rst_ni = 1'b0; req_valid_i = 1'b0; req_ocode_i = '0; req_vl_i = '0;
      req_scalar_i = 1'b0; req_rs1_i = '0; wb_ready_i = 1'b1;
      for (int i = 0; i < 32; i++) begin ma[i] = 32'h01010101 * i; mb[i] = 32'hFFFFFFFF; end
      @(negedge clk);
      chk_idle_outputs("reset");
      @(posedge clk); #1 rst_ni = 1'b1;

      ma[0] = 32'hF0F0F0F0; ma[1] = 32'hFFFF0000; mb[0] = 32'h0FF00FF0; mb[1] = 32'h12345678;
      start(OC_AND, 2, 1'b0, 32'h0);
      chk("and_busy", DW'(busy_o), 1);
      wait_done(20);
      chk("and_latency", DW'(done_at - hs_cyc), 7);
      chk("and_wb_cnt", DW'(wb_cnt - wb0), 2);
      chk("and_rd_cnt", DW'(rd_cnt - rd0), 2);
      chk("and_d0", wb_dat[wb0], 32'h00F000F0);
      chk("and_i0", DW'(wb_ix[wb0]), 0);
      chk("and_d1", wb_dat[wb0+1], 32'h12340000);
      chk("and_i1", DW'(wb_ix[wb0+1]), 1);

      ma[0] = 32'hAAAAAAAA; mb[0] = 32'h0000FFFF;
      start(OC_XNOR, 1, 1'b1, 32'h0);
      wait_done(20);
      chk("xnor_data", wb_dat[wb0], 32'hFFFF0000);
      chk("xnor_exec_a", exec_a, 0);
      chk("xnor_latency", DW'(done_at - hs_cyc), 4);

      ma[0] = 32'h00FF0000; mb[0] = 32'h0000000F;
      wb_ready_i = 1'b0;
      start(OC_OR, 1, 1'b0, 32'h0);
      repeat (6) @(posedge clk);
      #1 wb_ready_i = 1'b1;
      wait_done(20);
      chk("or_valid_cycles", DW'(vld_cnt - vl0), 5);
      chk("or_stable", DW'(unstable), 0);
      chk("or_data", wb_dat[wb0], 32'h00FF000F);
      chk("or_done_after_acc", DW'(done_at - acc_cyc), 1);

      start(OC_AND, 0, 1'b0, 32'h0);
      wait_done(10);
      chk("vl0_latency", DW'(done_at - hs_cyc), 1);
      chk("vl0_no_rw", DW'((rd_cnt - rd0) + (vld_cnt - vl0)), 0);
      chk("vl0_no_err", DW'(err_cnt - er0), 0);

      start(7'h7F, 3, 1'b0, 32'h0);
      wait_done(10);
      chk("ill_latency", DW'(done_at - hs_cyc), 1);
      chk("ill_err", DW'(err_cnt - er0), 1);
      chk("ill_err_with_done", DW'(err_cyc), DW'(done_at));
      chk("ill_no_rw", DW'((rd_cnt - rd0) + (vld_cnt - vl0)), 0);

      for (int i = 0; i < 32; i++) begin ma[i] = 32'h01010101 * i; mb[i] = 32'hFFFFFFFF; end
      start(OC_XOR, 8, 1'b0, 32'h0);
      begin
         int i = 0;
         while (!(wb_valid_o && wb_idx_o == 3) && i < 100) begin @(negedge clk); i++; end
      end
      chk("rst_reached_wb3", DW'(wb_valid_o && wb_idx_o == 3), 1);
      rst_ni = 1'b0;
      #1 chk_idle_outputs("midwb_rst");
      @(posedge clk); #1 rst_ni = 1'b1;
      ma[0] = 32'hF0F0F0F0; mb[0] = 32'h0FF00FF0;
      start(OC_OR, 1, 1'b0, 32'h0);
      wait_done(20);
      chk("post_rst_latency", DW'(done_at - hs_cyc), 4);
      chk("post_rst_data", wb_dat[wb0], 32'hFFF0FFF0);
      chk("post_rst_idx", DW'(wb_ix[wb0]), 0);

      for (int i = 0; i < 32; i++) begin ma[i] = 32'h01010101 * i; mb[i] = 32'hFFFFFFFF; end
      start(OC_AND, 40, 1'b0, 32'h0);
      wait_done(200);
      chk("sat_wb_cnt", DW'(wb_cnt - wb0), 32);
      chk("sat_last_idx", DW'(wb_ix[wb_cnt-1]), 31);
      chk("sat_last_data", wb_dat[wb_cnt-1], 32'h1F1F1F1F);
      chk("sat_latency", DW'(done_at - hs_cyc), 97);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
